memory_access: RTL



---
 rtl/memory_access_if.sv | 32 +++
 rtl/memory_access.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_if.sv
`timescale 1ns/1ps
// Data-bus port of the memory stage: one request at a time, held stable until
// the slave answers with mem_ready.
interface memory_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/memory_access.sv
`timescale 1ns/1ps
// RV32 memory stage: holds one instruction from execute, runs its load/store on
// the data bus, and hands an aligned, registered result bundle to writeback.
module memory_access (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           next_pc_in,
    input  logic [31:0]           alu_data_in,
    input  logic [31:0]           store_data_in,
    input  logic [31:0]           csr_data_in,
    input  logic                  load_in,
    input  logic                  store_in,
    input  logic [1:0]            size_in,
    input  logic                  signed_in,
    input  logic [1:0]            write_select_in,
    input  logic [4:0]            rd_address_in,
    input  logic [11:0]           csr_address_in,
    input  logic                  mret_in,
    input  logic                  wfi_in,
    input  logic                  valid_in,
    input  logic                  exception_in,
    input  logic [3:0]            ecause_in,
    input  logic                  flush_in,
    memory_access_if.master       mem,
    output logic                  busy_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           next_pc_out,
    output logic [31:0]           alu_data_out,
    output logic [31:0]           csr_data_out,
    output logic [31:0]           load_data_out,
    output logic [1:0]            write_select_out,
    output logic [4:0]            rd_address_out,
    output logic [11:0]           csr_address_out,
    output logic                  mret_out,
    output logic                  wfi_out,
    output logic                  valid_out,
    output logic                  exception_out,
    output logic [3:0]            ecause_out
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] store_strobes(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << a;
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic [1:0] size, input logic sgn);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {a, 3'b000};
        case (size)
            2'd0:    r = sgn ? {{24{s[7]}}, s[7:0]}   : {24'd0, s[7:0]};
            2'd1:    r = sgn ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // ---- stage register R (_p0) ----
    logic [31:0] pc_p0, next_pc_p0, alu_p0, store_data_p0, csr_data_p0;
    logic        load_p0, store_p0, signed_p0, mret_p0, wfi_p0, exception_p0;
    logic [1:0]  size_p0, write_select_p0;
    logic [4:0]  rd_address_p0;
    logic [11:0] csr_address_p0;
    logic [3:0]  ecause_p0;
    logic        vld_p0;

    logic        misaligned;
    logic        mem_op;
    logic        access_needed;
    logic        complete;
    logic        exc_nxt;
    logic [3:0]  cause_nxt;
    logic        req;
    state_t      state, state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
        end else if (!busy_out) begin
            vld_p0 <= valid_in & ~flush_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!busy_out) begin
            pc_p0           <= pc_in;
            next_pc_p0      <= next_pc_in;
            alu_p0          <= alu_data_in;
            store_data_p0   <= store_data_in;
            csr_data_p0     <= csr_data_in;
            load_p0         <= load_in;
            store_p0        <= store_in;
            size_p0         <= size_in;
            signed_p0       <= signed_in;
            write_select_p0 <= write_select_in;
            rd_address_p0   <= rd_address_in;
            csr_address_p0  <= csr_address_in;
            mret_p0         <= mret_in;
            wfi_p0          <= wfi_in;
            exception_p0    <= exception_in;
            ecause_p0       <= ecause_in;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (size_p0)
            2'd1:    misaligned = alu_p0[0];
            2'd2,
            2'd3:    misaligned = |alu_p0[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign mem_op        = load_p0 | store_p0;
    assign access_needed = vld_p0 & mem_op & ~exception_p0 & ~misaligned;
    assign busy_out      = access_needed & ~mem.mem_ready & ~flush_in;
    assign complete      = vld_p0 & (~access_needed | mem.mem_ready) & ~flush_in;

    // An earlier-stage exception outranks a misalignment found here.
    assign exc_nxt   = exception_p0 | (mem_op & misaligned);
    assign cause_nxt = exception_p0 ? ecause_p0 :
                       (mem_op & misaligned) ? (load_p0 ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN) :
                       ecause_p0;

    // ---- bus FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            S_IDLE: begin
                if (access_needed && !flush_in) begin
                    req = 1'b1;
                    if (!mem.mem_ready) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flushed request is simply dropped; nothing commits without mem_ready.
                if (flush_in) begin
                    state_nxt = S_IDLE;
                end else begin
                    req = access_needed;
                    if (mem.mem_ready || !access_needed) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = req & store_p0;
    assign mem.mem_addr  = {alu_p0[31:2], 2'b00};
    assign mem.mem_wdata = store_lanes(size_p0, store_data_p0);
    assign mem.mem_wstrb = (req & store_p0) ? store_strobes(size_p0, alu_p0[1:0]) : 4'b0000;

    // ---- writeback register W (_p1) ----
    logic [31:0] pc_p1, next_pc_p1, alu_p1, csr_data_p1, load_data_p1;
    logic [1:0]  write_select_p1;
    logic [4:0]  rd_address_p1;
    logic [11:0] csr_address_p1;
    logic        mret_p1, wfi_p1, exception_p1, vld_p1;
    logic [3:0]  ecause_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_p1           <= '0;
            next_pc_p1      <= '0;
            alu_p1          <= '0;
            csr_data_p1     <= '0;
            load_data_p1    <= '0;
            write_select_p1 <= '0;
            rd_address_p1   <= '0;
            csr_address_p1  <= '0;
            mret_p1         <= 1'b0;
            wfi_p1          <= 1'b0;
            exception_p1    <= 1'b0;
            ecause_p1       <= '0;
            vld_p1          <= 1'b0;
        end else if (complete) begin
            pc_p1           <= pc_p0;
            next_pc_p1      <= next_pc_p0;
            alu_p1          <= alu_p0;
            csr_data_p1     <= csr_data_p0;
            load_data_p1    <= (load_p0 & access_needed) ?
                               align_load(mem.mem_rdata, alu_p0[1:0], size_p0, signed_p0) : 32'd0;
            write_select_p1 <= write_select_p0;
            rd_address_p1   <= rd_address_p0;
            csr_address_p1  <= csr_address_p0;
            mret_p1         <= mret_p0;
            wfi_p1          <= wfi_p0;
            exception_p1    <= exc_nxt;
            ecause_p1       <= cause_nxt;
            vld_p1          <= 1'b1;
        end else begin
            load_data_p1    <= '0;
            rd_address_p1   <= '0;
            mret_p1         <= 1'b0;
            wfi_p1          <= 1'b0;
            exception_p1    <= 1'b0;
            ecause_p1       <= '0;
            vld_p1          <= 1'b0;
        end
    end

    assign pc_out           = pc_p1;
    assign next_pc_out      = next_pc_p1;
    assign alu_data_out     = alu_p1;
    assign csr_data_out     = csr_data_p1;
    assign load_data_out    = load_data_p1;
    assign write_select_out = write_select_p1;
    assign rd_address_out   = rd_address_p1;
    assign csr_address_out  = csr_address_p1;
    assign mret_out         = mret_p1;
    assign wfi_out          = wfi_p1;
    assign exception_out    = exception_p1;
    assign ecause_out       = ecause_p1;
    assign valid_out        = vld_p1;

endmodule
